hb_decim: RTL and testbench
===========================

Name: hb_decim

Overview:
- Parametrised, multi-channel halfband decimate-by-2 FIR. Successor to the fixed 16-bit mono hb1 stage.
- Sits in the decimation chain after the CIC (for example 128 kHz to 64 kHz at a 1.536 MHz clk).
- Channels arrive time-interleaved on one valid-strobed bus. A serial symmetric MAC is shared across channels, using the idle clocks between input samples.
- Adds a runtime bypass mode and an overrun flag.

Parameters:
- DATA_W, 16: input/output sample width, signed two's complement.
- COEF_W, 18: coefficient width, signed Q1.(COEF_W-1), so 1.0 = 2^(COEF_W-1).
- NTAPS, 11: filter length. Must be 4K+3. NPAIRS = (NTAPS+1)/4 symmetric non-zero pairs plus the centre tap.
- NCH, 2: number of interleaved channels, 1..8.
- COEFS, hb_pkg::HB_COEFS_11: array of NPAIRS pair coefficients, outermost first. Their sum must equal 0.25 (2^(COEF_W-3)).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- x_in  in  DATA_W  input sample.
- x_in_ch  in  CH_W  channel index of x_in. CH_W = max(1, $clog2(NCH)).
- x_in_valid  in  1  one-cycle strobe; x_in and x_in_ch are valid.
- bypass  in  1  1 = decimate without filtering. Sampled when a compute starts.
- y_out  out  DATA_W  output sample.
- y_out_ch  out  CH_W  channel of y_out.
- y_out_valid  out  1  one-cycle strobe.
- busy  out  1  MAC in progress.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high), one cycle, takes priority over everything:
  - y_out, y_out_ch, y_out_valid, busy, overrun = 0.
  - All delay lines = 0; all per-channel phase bits = 0; FSM returns to IDLE.
  - Asserting reset mid-MAC aborts the MAC with no output.
- Per channel: a delay line of NTAPS samples (index 0 = newest) and a phase bit.
- Input acceptance:
  - A sample is accepted when x_in_valid = 1, busy = 0 and x_in_ch < NCH.
  - On acceptance: shift the sample into that channel's line, then toggle its phase.
  - x_in_ch >= NCH: sample ignored, overrun is not set.
  - x_in_valid while busy = 1: sample dropped, line not shifted, overrun set (sticky until reset).
- Compute trigger: accepting a sample when that channel's phase was 1 (its 2nd, 4th, ... sample). The first sample after reset is phase 0.
- FSM states IDLE, PAIR, CENTER, ROUND.
  - IDLE: on a trigger, latch the channel and bypass. If bypass = 0, go to PAIR with the pair counter p = 0 and the accumulator cleared. busy = 1 from the cycle after the trigger.
  - PAIR: acc += COEFS[p] * (line[2p] + line[NTAPS-1-2p]). The pre-add is DATA_W+1 bits. When p = NPAIRS-1, go to CENTER.
  - CENTER: acc += line[(NTAPS-1)/2] << (COEF_W-2), which implements the 0.5 centre tap.
  - ROUND: y = floor((acc + 2^(COEF_W-2)) >> (COEF_W-1)), i.e. round half up, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - y_out_valid pulses the following cycle; busy drops with it.
    - Return to IDLE.
- Accumulator width: DATA_W + COEF_W + $clog2(NPAIRS) + 2 bits; no internal overflow.
- Filtered latency: y_out_valid occurs NPAIRS+3 cycles after the triggering x_in_valid (6 cycles at default parameters).
- Bypass compute:
  - y_out = the triggering sample itself, with y_out_valid one cycle after the trigger.
  - busy stays 0; the delay line still shifts.
- Between strobes, y_out and y_out_ch hold their last values.
- Throughput: each channel must be at least NPAIRS+3 clocks apart from the previous trigger. At default parameters with NCH = 2, an input every 6 clocks is legal.

Decomposition:
- hb_pkg holds:
  - COEF_W_DEFAULT;
  - HB_COEFS_11 = {1212, -8020, 39576}, which sums to 32768 = 0.25 in Q1.17;
  - the state enum hb_state_t;
  - a function ch_w(NCH).
- One sub-module, hb_delay_bank: NCH x NTAPS register lines with a write-shift port and two read taps, muxed by channel and pair index.
- The FSM, MAC, rounding and saturation live in hb_decim.

Test Plan:
- Impulse: ch0, 10000 on the phase-1 sample, zeros elsewhere, bypass = 0. Required ch0 outputs: 92, -612, 3019, 3019, -612, 92, then 0. An impulse on the phase-0 sample gives 0, 0, 5000, 0, ...
- DC: 1000 on ch0 and -1000 on ch1, interleaved every 6 clocks for 100 frames. Settles to exactly 1000 / -1000. Out:in count ratio per channel is 1:2. y_out_ch alternates 0/1.
- Step saturation: 32767 on ch0 starting at phase 0. Outputs are 303, -1702, 24575, then 32767 (overshoot to 137880/131072 saturates), ending at 32767. A -32768 step saturates at -32768.
- Bypass: bypass = 1 with ramp input 1, 2, 3, ... on ch0. Outputs are 2, 4, 6, ..., each 1 cycle after its trigger. busy is never 1.
- Overrun: two ch0/ch1 samples 2 clocks apart while busy. The second is dropped, overrun = 1 and stays 1, and no extra y_out_valid occurs.
- Reset mid-MAC: reset 2 cycles after a trigger. No y_out_valid follows. After release, the first sample is phase 0 and the impulse test repeats identically.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared constants, default coefficient table, FSM state type and channel-width helper
// for the hb_decim halfband decimator.
package hb_pkg;

  localparam int COEF_W_DEFAULT = 18;

  // Outermost pair first; 1212 - 8020 + 39576 = 32768 = 0.25 in Q1.17.
  localparam logic signed [COEF_W_DEFAULT-1:0] HB_COEFS_11 [3] =
    '{18'sd1212, -18'sd8020, 18'sd39576};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PAIR   = 2'd1,
    ST_CENTER = 2'd2,
    ST_ROUND  = 2'd3
  } hb_state_t;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/hb_delay_bank.sv
// Per-channel NTAPS-deep sample lines (index 0 = newest) with one shift port and two
// read taps: tap A reads line[2p] or the centre, tap B reads the mirrored line[NTAPS-1-2p].
module hb_delay_bank #(
  parameter int DATA_W = 16,
  parameter int NTAPS  = 11,
  parameter int NCH    = 2,
  parameter int CH_W   = 1,
  parameter int PW     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en_i,
  input  logic [CH_W-1:0]          shift_ch_i,
  input  logic signed [DATA_W-1:0] shift_data_i,
  input  logic [CH_W-1:0]          rd_ch_i,
  input  logic [PW-1:0]            rd_pair_i,
  input  logic                     rd_center_i,
  output logic signed [DATA_W-1:0] tap_a_o,
  output logic signed [DATA_W-1:0] tap_b_o
);

  localparam int TW = $clog2(NTAPS);

  logic signed [DATA_W-1:0] line_q [NCH][NTAPS];
  logic [TW-1:0]            idx_a_s;
  logic [TW-1:0]            idx_b_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < NTAPS; t++) begin
          line_q[c][t] <= '0;
        end
      end
    end else if (shift_en_i) begin
      line_q[shift_ch_i][0] <= shift_data_i;
      for (int t = 1; t < NTAPS; t++) begin
        line_q[shift_ch_i][t] <= line_q[shift_ch_i][t-1];
      end
    end
  end

  always_comb begin
    if (rd_center_i) begin
      idx_a_s = TW'((NTAPS - 1) / 2);
    end else begin
      idx_a_s = TW'(2 * int'(rd_pair_i));
    end
    idx_b_s = TW'(NTAPS - 1 - 2 * int'(rd_pair_i));
    tap_a_o = line_q[rd_ch_i][idx_a_s];
    tap_b_o = line_q[rd_ch_i][idx_b_s];
  end

endmodule

// File: rtl/hb_decim.sv
// Multi-channel halfband decimate-by-2 FIR: one serial symmetric MAC shared by all
// time-interleaved channels, with round-half-up, saturation, bypass and overrun flag.
module hb_decim
  import hb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = COEF_W_DEFAULT,
  parameter int NTAPS  = 11,
  parameter int NCH    = 2,
  parameter logic signed [COEF_W-1:0] COEFS [(NTAPS+1)/4] = HB_COEFS_11,
  localparam int CH_W  = ch_w(NCH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [CH_W-1:0]          x_in_ch,
  input  logic                     x_in_valid,
  input  logic                     bypass,
  output logic signed [DATA_W-1:0] y_out,
  output logic [CH_W-1:0]          y_out_ch,
  output logic                     y_out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int NPAIRS = (NTAPS + 1) / 4;
  localparam int PW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NPAIRS) + 2;
  localparam int PROD_W = COEF_W + DATA_W + 1;
  localparam logic signed [ACC_W-1:0] HALF  =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  hb_state_t                 state_q;
  logic [PW-1:0]             p_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [NCH-1:0]            phase_q;
  logic signed [DATA_W-1:0]  y_out_q, y_sat_d;
  logic [CH_W-1:0]           y_ch_q;
  logic                      y_valid_q, busy_q, overrun_q;

  logic                      accept_s, trigger_s;
  logic signed [DATA_W-1:0]  tap_a_s, tap_b_s;
  logic signed [DATA_W:0]    pre_s;
  logic signed [COEF_W-1:0]  coef_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   term_s, rnd_s, shr_s;

  assign accept_s  = x_in_valid && !busy_q && (int'(x_in_ch) < NCH);
  assign trigger_s = accept_s && phase_q[x_in_ch];

  hb_delay_bank #(
    .DATA_W(DATA_W), .NTAPS(NTAPS), .NCH(NCH), .CH_W(CH_W), .PW(PW)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .shift_en_i   (accept_s),
    .shift_ch_i   (x_in_ch),
    .shift_data_i (x_in),
    .rd_ch_i      (ch_q),
    .rd_pair_i    (p_q),
    .rd_center_i  (state_q == ST_CENTER),
    .tap_a_o      (tap_a_s),
    .tap_b_o      (tap_b_s)
  );

  always_comb begin
    pre_s  = {tap_a_s[DATA_W-1], tap_a_s} + {tap_b_s[DATA_W-1], tap_b_s};
    coef_s = COEFS[p_q];
    prod_s = coef_s * pre_s;
    case (state_q)
      ST_PAIR:   term_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
      // Centre tap is exactly 0.5, so it is a shift rather than a multiply.
      ST_CENTER: term_s = {{(ACC_W-DATA_W-COEF_W+2){tap_a_s[DATA_W-1]}}, tap_a_s,
                           {(COEF_W-2){1'b0}}};
      default:   term_s = '0;
    endcase
    acc_d = acc_q + term_s;
  end

  always_comb begin
    rnd_s = acc_q + HALF;
    shr_s = rnd_s >>> (COEF_W - 1);
    if (shr_s > Y_MAX) begin
      y_sat_d = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shr_s < Y_MIN) begin
      y_sat_d = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      y_sat_d = shr_s[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      y_out_q   <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (x_in_valid && busy_q) overrun_q <= 1'b1;
      if (accept_s) phase_q[x_in_ch] <= ~phase_q[x_in_ch];
      case (state_q)
        ST_IDLE: begin
          if (trigger_s) begin
            ch_q <= x_in_ch;
            if (bypass) begin
              y_out_q   <= x_in;
              y_ch_q    <= x_in_ch;
              y_valid_q <= 1'b1;
            end else begin
              state_q <= ST_PAIR;
              p_q     <= '0;
              acc_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_PAIR: begin
          acc_q <= acc_d;
          if (p_q == PW'(NPAIRS - 1)) state_q <= ST_CENTER;
          else p_q <= p_q + 1'b1;
        end
        ST_CENTER: begin
          acc_q   <= acc_d;
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          y_out_q   <= y_sat_d;
          y_ch_q    <= ch_q;
          y_valid_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y_out       = y_out_q;
  assign y_out_ch    = y_ch_q;
  assign y_out_valid = y_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hb_decim.sv
// Scoreboard bench for hb_decim: directed vectors push hand-computed outputs, a monitor
// pops and compares value, channel and arrival cycle on every y_out_valid.
module tb_hb_decim;

  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] x_in;
  logic [0:0]               x_in_ch;
  logic                     x_in_valid;
  logic                     bypass;
  logic signed [DATA_W-1:0] y_out;
  logic [0:0]               y_out_ch;
  logic                     y_out_valid;
  logic                     busy;
  logic                     overrun;

  hb_decim #(.DATA_W(16), .COEF_W(18), .NTAPS(11), .NCH(2)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_in_ch(x_in_ch), .x_in_valid(x_in_valid),
    .bypass(bypass), .y_out(y_out), .y_out_ch(y_out_ch), .y_out_valid(y_out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; int val; int at; } exp_t;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   out_cnt [2];
  bit   byp_win = 1'b0;
  int   busy_seen = 0;

  int imp1_exp  [7] = '{92, -612, 3019, 3019, -612, 92, 0};
  int imp0_exp  [7] = '{0, 0, 5000, 0, 0, 0, 0};
  int stepp_exp [7] = '{303, -1702, 24575, 32767, 32464, 32767, 32767};
  int stepn_exp [7] = '{-303, 1702, -24576, -32768, -32465, -32768, -32768};
  int ramp_exp  [7] = '{2, 4, 6, 8, 10, 12, 14};
  int dcp_exp   [5] = '{9, -52, 750, 1052, 991};
  int dcn_exp   [5] = '{-9, 52, -750, -1052, -991};

  exp_t mon_e;
  always @(negedge clk) begin
    if (byp_win && busy) busy_seen = busy_seen + 1;
    if (y_out_valid) begin
      checks = checks + 1;
      out_cnt[y_out_ch] = out_cnt[y_out_ch] + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL out_unexpected: got y=%0d ch=%0d at cyc %0d, required no output",
                 y_out, y_out_ch, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (int'(y_out) != mon_e.val || int'(y_out_ch) != mon_e.ch || cyc != mon_e.at) begin
          errors = errors + 1;
          $display("FAIL out_sample: got y=%0d ch=%0d cyc=%0d, required y=%0d ch=%0d cyc=%0d",
                   y_out, y_out_ch, cyc, mon_e.val, mon_e.ch, mon_e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send(input int ch, input int val, input bit byp, input bit trig,
                      input int expv, input int gap);
    exp_t e;
    @(negedge clk);
    x_in       = val[DATA_W-1:0];
    x_in_ch    = ch[0:0];
    bypass     = byp;
    x_in_valid = 1'b1;
    if (trig) begin
      e.ch  = ch;
      e.val = expv;
      e.at  = cyc + (byp ? 1 : 6);
      sb_q.push_back(e);
    end
    @(negedge clk);
    x_in_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    x_in_valid = 1'b0;
    bypass     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_y_out", int'(y_out), 0);
    chk("reset_y_out_ch", int'(y_out_ch), 0);
    chk("reset_y_out_valid", int'(y_out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk({name, "_pending"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // kind 0: impulse of 10000 at index prm; kind 1: constant prm; kind 2: ramp 1, 2, 3, ...
  task automatic run_ch0(input int kind, input int prm, input int vout [7],
                         input bit byp, input int gap);
    int v;
    for (int i = 0; i < 14; i++) begin
      case (kind)
        0:       v = (i == prm) ? 10000 : 0;
        1:       v = prm;
        default: v = i + 1;
      endcase
      send(0, v, byp, (i % 2) == 1, ((i % 2) == 1) ? vout[i/2] : 0, gap);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    reset = 1'b1; x_in = '0; x_in_ch = '0; x_in_valid = 1'b0; bypass = 1'b0;
    do_reset();

    run_ch0(0, 1, imp1_exp, 1'b0, 6);
    drain("impulse_ph1");

    do_reset();
    run_ch0(0, 0, imp0_exp, 1'b0, 6);
    drain("impulse_ph0");

    do_reset();
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    for (int f = 0; f < 100; f++) begin
      e0 = 1000;
      e1 = -1000;
      if ((f % 2) == 1 && (f - 1) / 2 < 5) begin
        e0 = dcp_exp[(f-1)/2];
        e1 = dcn_exp[(f-1)/2];
      end
      send(0, 1000, 1'b0, (f % 2) == 1, e0, 6);
      send(1, -1000, 1'b0, (f % 2) == 1, e1, 6);
    end
    drain("dc");
    chk("dc_count_ch0", out_cnt[0], 50);
    chk("dc_count_ch1", out_cnt[1], 50);

    do_reset();
    run_ch0(1, 32767, stepp_exp, 1'b0, 6);
    drain("step_pos");
    do_reset();
    run_ch0(1, -32768, stepn_exp, 1'b0, 6);
    drain("step_neg");

    do_reset();
    busy_seen = 0;
    byp_win   = 1'b1;
    run_ch0(2, 0, ramp_exp, 1'b1, 2);
    drain("bypass");
    byp_win = 1'b0;
    chk("bypass_busy_cycles", busy_seen, 0);

    do_reset();
    send(0, 0, 1'b0, 1'b0, 0, 6);
    send(0, 10000, 1'b0, 1'b1, 92, 2);
    send(1, 5000, 1'b0, 1'b0, 0, 6);
    chk("overrun_set", int'(overrun), 1);
    send(1, 0, 1'b0, 1'b0, 0, 6);
    drain("overrun");
    chk("overrun_sticky", int'(overrun), 1);

    do_reset();
    send(0, 0, 1'b0, 1'b0, 0, 6);
    send(0, 10000, 1'b0, 1'b0, 0, 2);
    do_reset();
    repeat (12) @(negedge clk);
    chk("midmac_busy", int'(busy), 0);
    run_ch0(0, 1, imp1_exp, 1'b0, 6);
    drain("midmac_impulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
